escritura_registros: RTL and testbench

Write-back stage for the MIPS datapath: the writer side of the register bank whose read ports feed the decode stage. It accepts ALU/memory results over a valid/ready handshake and buffers them in a small in-order queue. It drains one result per cycle into the bank write port. It also flags read-after-write hazards back to decode for any source register that still has a pending write.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/escritura_registros_if.sv | 46 ++++
 rtl/fifo_wb.sv | 116 +++++++++++
 rtl/escritura_registros.sv | 115 +++++++++++
 tb/tb_escritura_registros.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS datapath register-bank write-back path.
//   ANCHO_REG    : width of a register index
//   REG_CERO     : index of the hard-wired zero register
//   ANCHO_DATO   : default datapath width
//   entrada_wb_t : one pending write-back result (valid, destination, value)
//   es_reg_cero  : true when a register index names the zero register
// ----------------------------------------------------------------------------
package mips_pkg;

    localparam int ANCHO_REG  = 5;
    localparam int ANCHO_DATO = 32;

    localparam logic [ANCHO_REG-1:0] REG_CERO = 5'd0;

    typedef struct packed {
        logic                  valido;
        logic [ANCHO_REG-1:0]  rd;
        logic [ANCHO_DATO-1:0] dato;
    } entrada_wb_t;

    function automatic logic es_reg_cero(input logic [ANCHO_REG-1:0] r);
        return r == REG_CERO;
    endfunction

endpackage

// File: rtl/escritura_registros_if.sv
// ----------------------------------------------------------------------------
// escritura_registros_if
// Bundles the signals between the write-back stage and its neighbours:
//   producer handshake : ent_valido / ent_listo / ent_rd / ent_dato
//   bank write port    : banco_ocupado / we / waddr / wdata
//   decode hazard query: cons_rs / cons_rt -> riesgo_rs / riesgo_rt
//   occupancy          : cuenta
// master : the surrounding datapath (producer, bank, decode)
// slave  : the write-back stage itself
// ----------------------------------------------------------------------------
interface escritura_registros_if
    import mips_pkg::*;
#(
    parameter int PROFUNDIDAD = 4,
    parameter int ANCHO       = 32
);
    localparam int ANCHO_CUENTA = $clog2(PROFUNDIDAD) + 1;

    logic                    ent_valido;
    logic                    ent_listo;
    logic [ANCHO_REG-1:0]    ent_rd;
    logic [ANCHO-1:0]        ent_dato;

    logic                    banco_ocupado;
    logic                    we;
    logic [ANCHO_REG-1:0]    waddr;
    logic [ANCHO-1:0]        wdata;

    logic [ANCHO_REG-1:0]    cons_rs;
    logic [ANCHO_REG-1:0]    cons_rt;
    logic                    riesgo_rs;
    logic                    riesgo_rt;

    logic [ANCHO_CUENTA-1:0] cuenta;

    modport master (
        output ent_valido, ent_rd, ent_dato, banco_ocupado, cons_rs, cons_rt,
        input  ent_listo, we, waddr, wdata, riesgo_rs, riesgo_rt, cuenta
    );

    modport slave (
        input  ent_valido, ent_rd, ent_dato, banco_ocupado, cons_rs, cons_rt,
        output ent_listo, we, waddr, wdata, riesgo_rs, riesgo_rt, cuenta
    );

endinterface

// File: rtl/fifo_wb.sv
// ----------------------------------------------------------------------------
// fifo_wb
// In-order queue of pending register writes. Array storage with read/write
// pointers that wrap modulo PROFUNDIDAD and an explicit occupancy count.
// Every slot's valid bit and destination are exported so the hazard
// comparators can see all pending writes at once.
//   clk, rst          : clock, synchronous active-high reset
//   push/push_rd/dato : enqueue one entry (caller guarantees !lleno)
//   pop               : dequeue the head (caller guarantees !vacio)
//   head_rd/head_dato : head entry contents
//   cuenta            : entries queued
//   lleno / vacio     : full / empty
//   valido / rds      : per-slot valid bit and destination register
// ----------------------------------------------------------------------------
module fifo_wb
    import mips_pkg::*;
#(
    parameter int PROFUNDIDAD = 4,
    parameter int ANCHO       = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   push,
    input  logic [ANCHO_REG-1:0]                   push_rd,
    input  logic [ANCHO-1:0]                       push_dato,
    input  logic                                   pop,
    output logic [ANCHO_REG-1:0]                   head_rd,
    output logic [ANCHO-1:0]                       head_dato,
    output logic [$clog2(PROFUNDIDAD):0]           cuenta,
    output logic                                   lleno,
    output logic                                   vacio,
    output logic [PROFUNDIDAD-1:0]                 valido,
    output logic [PROFUNDIDAD-1:0][ANCHO_REG-1:0]  rds
);

    localparam int ANCHO_PTR    = $clog2(PROFUNDIDAD);
    localparam int ANCHO_CUENTA = ANCHO_PTR + 1;

    // Payload only; the valid bit lives in its own vector so it can be
    // reset without dragging the whole data array into the reset tree.
    typedef struct packed {
        logic [ANCHO_REG-1:0] rd;
        logic [ANCHO-1:0]     dato;
    } carga_t;

    carga_t                  mem_q [PROFUNDIDAD];

    logic [ANCHO_PTR-1:0]    rd_ptr_q, rd_ptr_d;
    logic [ANCHO_PTR-1:0]    wr_ptr_q, wr_ptr_d;
    logic [ANCHO_CUENTA-1:0] cuenta_q, cuenta_d;
    logic [PROFUNDIDAD-1:0]  valido_q, valido_d;

    // NOTE: every signal gets a default at the top of the always_comb so no
    // path leaves it unassigned; that is what keeps latches out.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cuenta_d = cuenta_q;
        valido_d = valido_q;

        // Pop clears before push sets. The same slot can only be hit by both
        // when the queue is full or empty, and the caller forbids those cases.
        if (pop) begin
            valido_d[rd_ptr_q] = 1'b0;
            rd_ptr_d           = rd_ptr_q + 1'b1;
        end
        if (push) begin
            valido_d[wr_ptr_q] = 1'b1;
            wr_ptr_d           = wr_ptr_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   cuenta_d = cuenta_q + 1'b1;
            2'b01:   cuenta_d = cuenta_q - 1'b1;
            default: cuenta_d = cuenta_q;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cuenta_q <= '0;
            valido_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cuenta_q <= cuenta_d;
            valido_q <= valido_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the valid bits and
    // the count decide what is meaningful, so stale payload is harmless.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{rd: push_rd, dato: push_dato};
        end
    end

    assign head_rd   = mem_q[rd_ptr_q].rd;
    assign head_dato = mem_q[rd_ptr_q].dato;
    assign cuenta    = cuenta_q;
    assign lleno     = (cuenta_q == ANCHO_CUENTA'(PROFUNDIDAD));
    assign vacio     = (cuenta_q == '0);
    assign valido    = valido_q;

    always_comb begin
        for (int i = 0; i < PROFUNDIDAD; i++) begin
            rds[i] = mem_q[i].rd;
        end
    end

endmodule

// File: rtl/escritura_registros.sv
// ----------------------------------------------------------------------------
// escritura_registros
// Write-back stage: accepts results over a valid/ready handshake, queues them
// in order, drains one per cycle into the register-bank write port and flags
// read-after-write hazards for the decode stage's source registers.
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : escritura_registros_if.slave
//          producer handshake in, registered bank write port out,
//          combinational hazard flags out, occupancy out
// Writes to register 0 complete the handshake but are dropped on the spot.
// ----------------------------------------------------------------------------
module escritura_registros
    import mips_pkg::*;
#(
    parameter int PROFUNDIDAD = 4,
    parameter int ANCHO       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    escritura_registros_if.slave  bus
);

    logic                                  push;
    logic                                  pop;
    logic [ANCHO_REG-1:0]                  head_rd;
    logic [ANCHO-1:0]                      head_dato;
    logic [$clog2(PROFUNDIDAD):0]          cuenta;
    logic                                  lleno;
    logic                                  vacio;
    logic [PROFUNDIDAD-1:0]                valido;
    logic [PROFUNDIDAD-1:0][ANCHO_REG-1:0] rds;

    logic                                  we_q, we_d;
    logic [ANCHO_REG-1:0]                  waddr_q, waddr_d;
    logic [ANCHO-1:0]                      wdata_q, wdata_d;

    logic                                  riesgo_rs_c;
    logic                                  riesgo_rt_c;

    // Ready depends only on occupancy: a full queue refuses even if the head
    // leaves in the same cycle, which keeps ent_listo off the bank path.
    assign bus.ent_listo = !lleno;

    // Register 0 never reaches the queue, so it can never be written or
    // raise a hazard.
    assign push = bus.ent_valido && bus.ent_listo && !es_reg_cero(bus.ent_rd);
    assign pop  = !vacio && !bus.banco_ocupado;

    fifo_wb #(
        .PROFUNDIDAD (PROFUNDIDAD),
        .ANCHO       (ANCHO)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_rd   (bus.ent_rd),
        .push_dato (bus.ent_dato),
        .pop       (pop),
        .head_rd   (head_rd),
        .head_dato (head_dato),
        .cuenta    (cuenta),
        .lleno     (lleno),
        .vacio     (vacio),
        .valido    (valido),
        .rds       (rds)
    );

    // Registered bank write port: address/data hold when nothing pops.
    always_comb begin
        we_d    = pop;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (pop) begin
            waddr_d = head_rd;
            wdata_d = head_dato;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // A write stays pending until the bank has actually taken it, so the
    // registered port is checked alongside the queued entries. The incoming
    // result on the handshake is intentionally left out.
    always_comb begin
        logic coincide_rs;
        logic coincide_rt;
        coincide_rs = we_q && (waddr_q == bus.cons_rs);
        coincide_rt = we_q && (waddr_q == bus.cons_rt);
        for (int i = 0; i < PROFUNDIDAD; i++) begin
            if (valido[i] && (rds[i] == bus.cons_rs)) coincide_rs = 1'b1;
            if (valido[i] && (rds[i] == bus.cons_rt)) coincide_rt = 1'b1;
        end
        riesgo_rs_c = coincide_rs && !es_reg_cero(bus.cons_rs);
        riesgo_rt_c = coincide_rt && !es_reg_cero(bus.cons_rt);
    end

    assign bus.we        = we_q;
    assign bus.waddr     = waddr_q;
    assign bus.wdata     = wdata_q;
    assign bus.riesgo_rs = riesgo_rs_c;
    assign bus.riesgo_rt = riesgo_rt_c;
    assign bus.cuenta    = cuenta;

endmodule

// File: tb/tb_escritura_registros.sv
// ----------------------------------------------------------------------------
// tb_escritura_registros
// Directed scenarios followed by a randomized phase. A queue-level reference
// model predicts every output each cycle; scenario-specific expectations are
// checked on top of that.
// ----------------------------------------------------------------------------
module tb_escritura_registros;

    localparam int PROF = 4;
    localparam int AN   = 32;

    typedef struct {
        logic [4:0]    rd;
        logic [AN-1:0] dato;
    } ent_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    escritura_registros_if #(.PROFUNDIDAD(PROF), .ANCHO(AN)) bus ();

    escritura_registros #(.PROFUNDIDAD(PROF), .ANCHO(AN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int misc    = 0;

    // Reference model: pending results in arrival order plus the bank port.
    ent_t          mq[$];
    logic          m_we;
    logic [4:0]    m_waddr;
    logic [AN-1:0] m_wdata;
    bit            modelo_ok = 1'b0;

    // Bank writes seen on the port, for ordering checks.
    ent_t          log_wr[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            misc++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic riesgo_modelo(input logic [4:0] c);
        if (c == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].rd == c) return 1'b1;
        return m_we && (m_waddr == c);
    endfunction

    // One clock cycle: drive inputs, compare outputs against the model,
    // then advance the model across the rising edge.
    task automatic step(input logic v, input logic [4:0] rd, input logic [AN-1:0] d,
                        input logic bo, input logic [4:0] rs, input logic [4:0] rt,
                        input logic r);
        int   n;
        logic hay_pop;
        logic acepta;
        @(negedge clk);
        rst               = r;
        bus.ent_valido    = v;
        bus.ent_rd        = rd;
        bus.ent_dato      = d;
        bus.banco_ocupado = bo;
        bus.cons_rs       = rs;
        bus.cons_rt       = rt;
        #1;
        if (modelo_ok) begin
            check("ent_listo", bus.ent_listo, (mq.size() < PROF));
            check("cuenta",    bus.cuenta,    mq.size());
            check("we",        bus.we,        m_we);
            check("waddr",     bus.waddr,     m_waddr);
            check("wdata",     bus.wdata,     m_wdata);
            check("riesgo_rs", bus.riesgo_rs, riesgo_modelo(rs));
            check("riesgo_rt", bus.riesgo_rt, riesgo_modelo(rt));
        end
        if (bus.we === 1'b1) log_wr.push_back('{bus.waddr, bus.wdata});
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_we      = 1'b0;
            m_waddr   = '0;
            m_wdata   = '0;
            modelo_ok = 1'b1;
        end else begin
            n       = mq.size();
            hay_pop = (n > 0) && !bo;
            acepta  = v && (n < PROF);
            if (hay_pop) begin
                m_we    = 1'b1;
                m_waddr = mq[0].rd;
                m_wdata = mq[0].dato;
                mq.delete(0);
            end else begin
                m_we = 1'b0;
            end
            if (acepta && (rd != 5'd0)) mq.push_back('{rd, d});
        end
    endtask

    task automatic idle(input int ciclos, input logic bo);
        for (int i = 0; i < ciclos; i++) step(1'b0, 5'd0, '0, bo, 5'd0, 5'd0, 1'b0);
    endtask

    initial begin
        // ---------------- reset ----------------
        step(1'b1, 5'd3, 32'h1, 1'b0, 5'd0, 5'd0, 1'b1);
        step(1'b1, 5'd3, 32'h1, 1'b0, 5'd0, 5'd0, 1'b1);
        #2;
        check("rst_listo",  bus.ent_listo, 1'b1);
        check("rst_cuenta", bus.cuenta,    0);
        check("rst_we",     bus.we,        1'b0);
        check("rst_waddr",  bus.waddr,     0);
        check("rst_wdata",  bus.wdata,     0);

        // ---------------- single write ----------------
        log_wr.delete();
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 1'b0);
        idle(4, 1'b0);
        check("single_nwr", log_wr.size(), 1);
        if (log_wr.size() > 0) begin
            check("single_waddr", log_wr[0].rd,   5);
            check("single_wdata", log_wr[0].dato, 32'hDEADBEEF);
        end
        check("single_cuenta", bus.cuenta, 0);

        // ---------------- fill and back-pressure ----------------
        log_wr.delete();
        for (int i = 1; i <= 5; i++) step(1'b1, 5'(i), 32'h100 + i, 1'b1, 5'd0, 5'd0, 1'b0);
        step(1'b1, 5'd5, 32'h105, 1'b1, 5'd0, 5'd0, 1'b0);
        #2;
        check("full_listo",  bus.ent_listo, 1'b0);
        check("full_cuenta", bus.cuenta,    4);
        step(1'b1, 5'd5, 32'h105, 1'b0, 5'd0, 5'd0, 1'b0);
        step(1'b1, 5'd5, 32'h105, 1'b0, 5'd0, 5'd0, 1'b0);
        idle(6, 1'b0);
        check("fill_nwr", log_wr.size(), 5);
        for (int i = 0; i < 5 && i < log_wr.size(); i++) begin
            check("fill_order_rd",   log_wr[i].rd,   i + 1);
            check("fill_order_dato", log_wr[i].dato, 32'h101 + i);
        end

        // ---------------- register 0 ----------------
        log_wr.delete();
        step(1'b1, 5'd0, 32'd7, 1'b0, 5'd0, 5'd0, 1'b0);
        #2;
        check("r0_cuenta", bus.cuenta,    0);
        check("r0_riesgo", bus.riesgo_rs, 1'b0);
        idle(3, 1'b0);
        check("r0_nwr", log_wr.size(), 0);

        // ---------------- hazard ----------------
        step(1'b1, 5'd8, 32'h88, 1'b1, 5'd8, 5'd9, 1'b0);
        step(1'b0, 5'd0, 32'h0,  1'b1, 5'd8, 5'd9, 1'b0);
        step(1'b0, 5'd0, 32'h0,  1'b0, 5'd8, 5'd9, 1'b0);
        step(1'b0, 5'd0, 32'h0,  1'b0, 5'd8, 5'd9, 1'b0);
        step(1'b0, 5'd0, 32'h0,  1'b0, 5'd8, 5'd9, 1'b0);

        // ---------------- same rd with concurrent push/pop ----------------
        log_wr.delete();
        for (int i = 1; i <= 3; i++) step(1'b1, 5'd3, AN'(i), 1'b0, 5'd3, 5'd0, 1'b0);
        idle(3, 1'b0);
        check("same_nwr", log_wr.size(), 3);
        for (int i = 0; i < 3 && i < log_wr.size(); i++) begin
            check("same_order", log_wr[i].dato, i + 1);
        end

        // ---------------- reset mid-drain ----------------
        for (int i = 1; i <= 3; i++) step(1'b1, 5'(10 + i), 32'hA0 + i, 1'b1, 5'd11, 5'd12, 1'b0);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd11, 5'd12, 1'b0);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd11, 5'd12, 1'b1);
        #2;
        check("mid_rst_we",  bus.we,        1'b0);
        check("mid_rst_cnt", bus.cuenta,    0);
        check("mid_rst_rs",  bus.riesgo_rs, 1'b0);
        check("mid_rst_rt",  bus.riesgo_rt, 1'b0);
        log_wr.delete();
        idle(4, 1'b0);
        check("mid_rst_stale", log_wr.size(), 0);

        // ---------------- randomized ----------------
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0),
                 5'($urandom_range(0, 7)),
                 $urandom,
                 1'($urandom_range(0, 2) == 0),
                 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 63) == 0));
        end
        idle(6, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule
